mem_port_arbiter: RTL and testbench

Shares the single-port unified memory between the instruction-fetch requester and the load/store requester of the RV32I core. It drives the physical memory port and enforces one outstanding access at a time. Grants follow a fixed data-first priority, and each read waits out the fixed memory read latency. Store byte enables are produced from the store-width code emitted by `control` (WSel: 0 = word, 1 = half, 2 = byte).

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_be_gen.sv | 34 +++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter:
// FSM state encoding, requester-owner encoding and store-width codes.
package mem_arb_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    // Which requester owns the read currently in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    // Store-width codes as emitted by the control unit; code 3 behaves as word.
    localparam logic [1:0] WSEL_WORD = 2'd0;
    localparam logic [1:0] WSEL_HALF = 2'd1;
    localparam logic [1:0] WSEL_BYTE = 2'd2;

endpackage

// File: rtl/mem_be_gen.sv
// Store lane steering: turns a store-width code and the low address bits
// into byte enables, and replicates narrow store data across all lanes so
// the enabled lane always carries the right bytes.
module mem_be_gen
    import mem_arb_pkg::*;
(
    input  logic [1:0]  wsel,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep
);

    // Decode width code; half stores ignore addr_lo[0] (no misaligned halves).
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        case (wsel)
            WSEL_HALF: begin
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            WSEL_BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (if_*)
// and load/store (ls_*). One access outstanding at a time; load/store has
// priority. Stores complete in the grant cycle; reads park the FSM in
// RD_WAIT until the memory read latency has elapsed.
//
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to force a fetch grant
// after STARVE_MAX consecutive load/store wins against a waiting fetch.
//
// Handshake: a requester holds *_req (and its address/data) until it sees
// *_gnt high in the same cycle; *_gnt is combinational from *_req and only
// ever asserted in IDLE. *_rvalid is a single-cycle pulse qualifying *_rdata.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [1:0]    ls_wsel,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output state_e        dbg_state
);

    // Counter only needs to hold MEM_LAT-1.
    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    // Reject parameter values the timing scheme cannot express.
    if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_bad_params
        $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    owner_e        owner_q, owner_d;
    logic [AW-1:0] addr_sel;
    logic [3:0]    gen_be;
    logic [DW-1:0] gen_wdata;
    logic          force_if;

    mem_be_gen u_be_gen (
        .wsel      (ls_wsel),
        .addr_lo   (ls_addr[1:0]),
        .wdata     (ls_wdata),
        .be        (gen_be),
        .wdata_rep (gen_wdata)
    );

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q;

    assign force_if = if_req && (starve_q >= SW'(STARVE_MAX));

    // Count consecutive load/store wins while fetch waits; any fetch grant
    // or a fetch that stops asking clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else if (!if_req || if_gnt) begin
            starve_q <= '0;
        end else if (ls_gnt && (starve_q < SW'(STARVE_MAX))) begin
            starve_q <= starve_q + SW'(1);
        end
    end
`else
    assign force_if = 1'b0;
`endif

    // State, latency counter and read owner; reset abandons any pending read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_IF;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
        end
    end

    // Arbitration, memory strobe generation and read-return routing.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        if_rdata  = '0;
        ls_rdata  = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        mem_wdata = '0;
        addr_sel  = '0;
        case (state_q)
            IDLE: begin
                if (ls_req && !force_if) begin
                    ls_gnt   = 1'b1;
                    mem_en   = 1'b1;
                    addr_sel = ls_addr;
                    if (ls_we) begin
                        mem_we    = 1'b1;
                        mem_be    = gen_be;
                        mem_wdata = gen_wdata;
                    end else begin
                        state_d = RD_WAIT;
                        cnt_d   = CNT_LOAD;
                        owner_d = OWN_LS;
                    end
                end else if (if_req) begin
                    if_gnt   = 1'b1;
                    mem_en   = 1'b1;
                    addr_sel = if_addr;
                    state_d  = RD_WAIT;
                    cnt_d    = CNT_LOAD;
                    owner_d  = OWN_IF;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (owner_q == OWN_LS) begin
                        ls_rvalid = 1'b1;
                        ls_rdata  = mem_rdata;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory is word addressed: drop the byte offset.
    assign mem_addr  = addr_sel & ~AW'(3);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-accurate memory model
// and read-return scoreboards. Inputs change 1 time unit after the rising
// edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          if_req, if_gnt, if_rvalid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          ls_req, ls_we, ls_gnt, ls_rvalid;
  logic [1:0]    ls_wsel;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata, ls_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  state_e        dbg_state;

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_wsel(ls_wsel), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid),
    .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- memory model ----------------
  function automatic logic [31:0] rdata_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  logic [31:0] rd_pipe [MEM_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= (mem_en && !mem_we) ? rdata_fn(mem_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_ls_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  // Every read return must match the oldest expected value for its port.
  always @(negedge clk) begin
    if (rst_n && if_rvalid) begin
      if (exp_if_q.size() == 0) chk("if_rvalid_unexpected", {31'b0, if_rvalid}, 32'd0);
      else chk("if_rdata", if_rdata, exp_if_q.pop_front());
    end
    if (rst_n && ls_rvalid) begin
      if (exp_ls_q.size() == 0) chk("ls_rvalid_unexpected", {31'b0, ls_rvalid}, 32'd0);
      else chk("ls_rdata", ls_rdata, exp_ls_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  // Single read, checking grant, strobe and exact return cycle.
  task automatic do_read(input logic is_ls, input logic [31:0] addr);
    if (is_ls) begin
      ls_req = 1'b1; ls_we = 1'b0; ls_addr = addr;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
    look();
    chk("rd_own_gnt", {31'b0, (is_ls ? ls_gnt : if_gnt)}, 32'd1);
    chk("rd_other_gnt", {31'b0, (is_ls ? if_gnt : ls_gnt)}, 32'd0);
    chk("rd_mem_en", {31'b0, mem_en}, 32'd1);
    chk("rd_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rd_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
    if (is_ls) exp_ls_q.push_back(rdata_fn(addr & 32'hFFFF_FFFC));
    else exp_if_q.push_back(rdata_fn(addr & 32'hFFFF_FFFC));
    step();
    ls_req = 1'b0; if_req = 1'b0;
    for (int k = 1; k <= MEM_LAT; k++) begin
      look();
      chk("rd_rvalid_timing", {31'b0, (is_ls ? ls_rvalid : if_rvalid)}, {31'b0, (k == MEM_LAT)});
      chk("rd_wait_mem_en", {31'b0, mem_en}, 32'd0);
      step();
    end
  endtask

  // Store in the current cycle; keep=1 leaves the request up for the next one.
  task automatic do_store(input logic [31:0] addr, input logic [1:0] wsel,
                          input logic [31:0] wdata, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic keep);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = addr; ls_wsel = wsel; ls_wdata = wdata;
    look();
    chk("st_ls_gnt", {31'b0, ls_gnt}, 32'd1);
    chk("st_mem_we", {31'b0, mem_we}, 32'd1);
    chk("st_mem_be", {28'b0, mem_be}, {28'b0, exp_be});
    chk("st_mem_wdata", mem_wdata, exp_wdata);
    chk("st_mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
    step();
    if (!keep) begin
      ls_req = 1'b0; ls_we = 1'b0;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    rst_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_wsel = WSEL_WORD; ls_addr = '0; ls_wdata = '0;
    repeat (3) @(posedge clk);
    look();
    chk("rst_if_gnt", {31'b0, if_gnt}, 32'd0);
    chk("rst_ls_gnt", {31'b0, ls_gnt}, 32'd0);
    chk("rst_if_rvalid", {31'b0, if_rvalid}, 32'd0);
    chk("rst_ls_rvalid", {31'b0, ls_rvalid}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_ls_rdata", ls_rdata, 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    step();
    rst_n = 1'b1;
    step();

    // Fetch-only read at 0x100.
    do_read(1'b0, 32'h0000_0100);

    // Back-to-back reads: load then fetch, second grant at T+MEM_LAT+1.
    do_read(1'b1, 32'h0000_0046);
    do_read(1'b0, 32'h0000_0104);

    // Simultaneous fetch + load: load first, fetch at T+3, its data at T+5.
    if_req = 1'b1; if_addr = 32'h140;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h306;
    look();
    chk("sim_ls_gnt", {31'b0, ls_gnt}, 32'd1);
    chk("sim_if_gnt_t0", {31'b0, if_gnt}, 32'd0);
    chk("sim_mem_addr_ls", mem_addr, 32'h304);
    exp_ls_q.push_back(rdata_fn(32'h304));
    step();
    ls_req = 1'b0;
    look();
    chk("sim_if_gnt_t1", {31'b0, if_gnt}, 32'd0);
    chk("sim_state_t1", 32'(dbg_state), 32'(RD_WAIT));
    step();
    look();
    chk("sim_ls_rvalid_t2", {31'b0, ls_rvalid}, 32'd1);
    chk("sim_if_gnt_t2", {31'b0, if_gnt}, 32'd0);
    step();
    look();
    chk("sim_if_gnt_t3", {31'b0, if_gnt}, 32'd1);
    chk("sim_mem_addr_if", mem_addr, 32'h140);
    exp_if_q.push_back(rdata_fn(32'h140));
    step();
    if_req = 1'b0;
    look();
    chk("sim_if_rvalid_t4", {31'b0, if_rvalid}, 32'd0);
    step();
    look();
    chk("sim_if_rvalid_t5", {31'b0, if_rvalid}, 32'd1);
    step();

    // Store widths and lane steering.
    do_store(32'h203, WSEL_BYTE, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB, 1'b0);
    look();
    chk("st_no_ls_rvalid", {31'b0, ls_rvalid}, 32'd0);
    chk("st_state_idle", 32'(dbg_state), 32'(IDLE));
    step();
    do_store(32'h202, WSEL_HALF, 32'hFFFF_1234, 4'b1100, 32'h1234_1234, 1'b0);
    do_store(32'h201, WSEL_HALF, 32'h0000_BEEF, 4'b0011, 32'hBEEF_BEEF, 1'b0);
    do_store(32'h201, WSEL_BYTE, 32'h0000_0055, 4'b0010, 32'h5555_5555, 1'b0);
    do_store(32'h208, WSEL_BYTE, 32'h0000_0077, 4'b0001, 32'h7777_7777, 1'b0);
    do_store(32'h20E, 2'd3,      32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D, 1'b0);

    // Five back-to-back word stores, one grant per cycle.
    for (int n = 0; n < 5; n++) begin
      d = $urandom;
      do_store({20'h0, 4'h4, 4'($urandom_range(0, 15)), 4'b0000}, WSEL_WORD, d,
               4'b1111, d, (n < 4));
    end
    look();
    chk("b2b_end_gnt", {31'b0, ls_gnt}, 32'd0);
    chk("b2b_end_mem_en", {31'b0, mem_en}, 32'd0);
    step();

    // Fetch held against a continuous stream of stores.
    if_req = 1'b1; if_addr = 32'h1C0;
    ls_req = 1'b1; ls_we = 1'b1; ls_wsel = WSEL_WORD;
`ifdef MEM_ARB_STARVE_GUARD_EN
    for (int n = 0; n < STARVE_MAX; n++) begin
      ls_addr = 32'($urandom_range(0, 255)) << 2; ls_wdata = $urandom;
      look();
      chk("guard_ls_gnt", {31'b0, ls_gnt}, 32'd1);
      chk("guard_if_held", {31'b0, if_gnt}, 32'd0);
      step();
    end
    look();
    chk("guard_if_forced", {31'b0, if_gnt}, 32'd1);
    chk("guard_ls_blocked", {31'b0, ls_gnt}, 32'd0);
    chk("guard_mem_addr", mem_addr, 32'h1C0);
    exp_if_q.push_back(rdata_fn(32'h1C0));
    step();
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
`else
    for (int n = 0; n < STARVE_MAX + 2; n++) begin
      ls_addr = 32'($urandom_range(0, 255)) << 2; ls_wdata = $urandom;
      look();
      chk("strict_ls_gnt", {31'b0, ls_gnt}, 32'd1);
      chk("strict_if_starved", {31'b0, if_gnt}, 32'd0);
      step();
    end
    ls_req = 1'b0; ls_we = 1'b0;
    look();
    chk("strict_if_gnt_after", {31'b0, if_gnt}, 32'd1);
    exp_if_q.push_back(rdata_fn(32'h1C0));
    step();
    if_req = 1'b0;
`endif
    look();
    chk("starve_if_rvalid_early", {31'b0, if_rvalid}, 32'd0);
    step();
    look();
    chk("starve_if_rvalid", {31'b0, if_rvalid}, 32'd1);
    step();

    // Reset during a read: the pending return is dropped.
    if_req = 1'b1; if_addr = 32'h180;
    look();
    chk("rr_if_gnt", {31'b0, if_gnt}, 32'd1);
    step();
    if_req = 1'b0;
    rst_n = 1'b0;
    look();
    chk("rr_state_idle", 32'(dbg_state), 32'(IDLE));
    chk("rr_if_rvalid_t1", {31'b0, if_rvalid}, 32'd0);
    step();
    look();
    chk("rr_if_rvalid_t2", {31'b0, if_rvalid}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    do_read(1'b1, 32'h0000_0040);

    repeat (4) step();
    look();
    chk("if_queue_drained", 32'(exp_if_q.size()), 32'd0);
    chk("ls_queue_drained", 32'(exp_ls_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
